// File: rtl/acc_cpu_mc.sv
// acc_cpu_mc: multi-cycle accumulator CPU core.
//
// Each instruction is fetched and then executed in two separate cycles. Loads
// and stores to data memory add a MEM phase, which waits as long as needed for
// an acknowledge from the memory. The HALT instruction stops the core until
// the next clr.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   clr       synchronous active-high reset
//   pm_addr   program memory address (= pc)
//   pm_data   instruction word from combinational program memory
//   dm_req    data-memory request, held until dm_ack
//   dm_we     1 = write, 0 = read; valid while dm_req
//   dm_addr   data-memory address; valid while dm_req
//   dm_wdata  write data (= acc); valid while dm_req
//   dm_rdata  read data, sampled in the cycle dm_ack is high
//   dm_ack    one-cycle completion strobe from data memory
//   o_data    accumulator value
//   o_zero    zero flag
//   o_carry   carry/borrow flag
//   o_halted  high while in HALT
module acc_cpu_mc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 5,
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned NREG   = 8
) (
    input  logic              clk,
    input  logic              clr,
    output logic [PC_W-1:0]   pm_addr,
    input  logic [15:0]       pm_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [MEM_AW-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic [DATA_W-1:0] o_data,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_halted
);

    localparam int unsigned RIW = (NREG > 1) ? $clog2(NREG) : 1;

    // Opcode 0 (NOP) has no entry: it falls through to the default pc+1 path.
    localparam logic [3:0] OpLdi  = 4'h1;
    localparam logic [3:0] OpLdr  = 4'h2;
    localparam logic [3:0] OpStr  = 4'h3;
    localparam logic [3:0] OpAdd  = 4'h4;
    localparam logic [3:0] OpSub  = 4'h5;
    localparam logic [3:0] OpAnd  = 4'h6;
    localparam logic [3:0] OpOr   = 4'h7;
    localparam logic [3:0] OpXor  = 4'h8;
    localparam logic [3:0] OpLdm  = 4'h9;
    localparam logic [3:0] OpStm  = 4'hA;
    localparam logic [3:0] OpJmp  = 4'hB;
    localparam logic [3:0] OpJz   = 4'hC;
    localparam logic [3:0] OpMul  = 4'hD;
    localparam logic [3:0] OpAddi = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [15:0]         ir_q, ir_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic                reg_we;
    logic                acc_we;

    logic [3:0]          op;
    logic [DATA_W-1:0]   imm;
    logic [MEM_AW-1:0]   mem_addr;
    logic [PC_W-1:0]     target;
    logic [RIW-1:0]      r_idx;
    logic [DATA_W-1:0]   rval;
    logic [DATA_W-1:0]   prod;
    logic [DATA_W:0]     sum_r;
    logic [DATA_W:0]     sum_i;
    logic                unused_ir;

    assign op       = ir_q[15:12];
    assign imm      = ir_q[DATA_W-1:0];
    assign mem_addr = ir_q[MEM_AW-1:0];
    assign target   = ir_q[PC_W-1:0];
    // Register index bits above NREG-1 wrap modulo NREG.
    assign r_idx    = RIW'(32'(ir_q[2:0]) % NREG);
    assign rval     = regs_q[r_idx];
    // Product is truncated to the low DATA_W bits by the assignment width.
    assign prod     = acc_q * rval;
    assign sum_r    = {1'b0, acc_q} + {1'b0, rval};
    assign sum_i    = {1'b0, acc_q} + {1'b0, imm};
    // Operand bits not consumed by every parameterisation.
    assign unused_ir = ^ir_q[11:0];

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: state_d = StExec;
            StExec: begin
                if (op == OpLdm || op == OpStm) begin
                    state_d = StMem;
                end else if (op == OpHalt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            StMem: begin
                if (dm_ack) begin
                    state_d = StFetch;
                end
            end
            StHalt: state_d = StHalt;
        endcase
    end

    // Outputs are decoded from registered state and ir only, so they cannot
    // glitch within a cycle and are zero outside MEM.
    always_comb begin
        dm_req   = (state_q == StMem);
        dm_we    = (state_q == StMem) && (op == OpStm);
        dm_addr  = (state_q == StMem) ? mem_addr : '0;
        dm_wdata = (state_q == StMem) ? acc_q : '0;
        o_halted = (state_q == StHalt);
        pm_addr  = pc_q;
        o_data   = acc_q;
        o_zero   = zero_q;
        o_carry  = carry_q;
    end

    // Datapath next-state
    always_comb begin
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        reg_we  = 1'b0;
        acc_we  = 1'b0;
        case (state_q)
            StFetch: ir_d = pm_data;
            StExec: begin
                pc_d = pc_q + PC_W'(1);
                case (op)
                    OpLdi: begin
                        acc_d  = imm;
                        acc_we = 1'b1;
                    end
                    OpLdr: begin
                        acc_d  = rval;
                        acc_we = 1'b1;
                    end
                    OpStr: reg_we = 1'b1;
                    OpAdd: begin
                        {carry_d, acc_d} = sum_r;
                        acc_we = 1'b1;
                    end
                    OpSub: begin
                        acc_d   = acc_q - rval;
                        carry_d = (acc_q < rval);
                        acc_we  = 1'b1;
                    end
                    OpAnd: begin
                        acc_d  = acc_q & rval;
                        acc_we = 1'b1;
                    end
                    OpOr: begin
                        acc_d  = acc_q | rval;
                        acc_we = 1'b1;
                    end
                    OpXor: begin
                        acc_d  = acc_q ^ rval;
                        acc_we = 1'b1;
                    end
                    OpMul: begin
                        acc_d   = prod;
                        carry_d = 1'b0;
                        acc_we  = 1'b1;
                    end
                    OpAddi: begin
                        {carry_d, acc_d} = sum_i;
                        acc_we = 1'b1;
                    end
                    OpJmp: pc_d = target;
                    OpJz: begin
                        if (zero_q) begin
                            pc_d = target;
                        end
                    end
                    // Memory ops advance pc on ack; HALT freezes pc.
                    OpLdm, OpStm, OpHalt: pc_d = pc_q;
                    default: ;
                endcase
            end
            StMem: begin
                if (dm_ack) begin
                    pc_d = pc_q + PC_W'(1);
                    if (op == OpLdm) begin
                        acc_d  = dm_rdata;
                        acc_we = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (acc_we) begin
            zero_d = (acc_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[r_idx] <= acc_q;
        end
    end

endmodule

// File: tb/tb_acc_cpu_mc.sv
module tb_acc_cpu_mc;

    localparam int NV = 11;
    localparam logic [15:0] HaltIns = 16'hF000;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [4:0]  pm_addr;
    logic [15:0] pm_data;
    logic        dm_req, dm_we;
    logic [9:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic [7:0]  dm_rdata = 8'h00;
    logic        dm_ack = 1'b0;
    logic [7:0]  o_data;
    logic        o_zero, o_carry, o_halted;

    logic [4:0]  pm_addr12;
    logic [15:0] pm_data12;
    logic        dm_req12, dm_we12;
    logic [9:0]  dm_addr12;
    logic [11:0] dm_wdata12;
    logic [11:0] dm_rdata12 = 12'h000;
    logic        dm_ack12 = 1'b0;
    logic [11:0] o_data12;
    logic        o_zero12, o_carry12, o_halted12;

    logic [15:0] pm   [32];
    logic [15:0] pm12 [32];
    logic [7:0]  dmem [1024];

    assign pm_data   = pm[pm_addr];
    assign pm_data12 = pm12[pm_addr12];

    always #5 clk = ~clk;

    acc_cpu_mc #(.DATA_W(8), .PC_W(5), .MEM_AW(10), .NREG(8)) u_dut (
        .clk(clk), .clr(clr), .pm_addr(pm_addr), .pm_data(pm_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .o_data(o_data), .o_zero(o_zero),
        .o_carry(o_carry), .o_halted(o_halted)
    );

    acc_cpu_mc #(.DATA_W(12), .PC_W(5), .MEM_AW(10), .NREG(8)) u_dut12 (
        .clk(clk), .clr(clr), .pm_addr(pm_addr12), .pm_data(pm_data12),
        .dm_req(dm_req12), .dm_we(dm_we12), .dm_addr(dm_addr12), .dm_wdata(dm_wdata12),
        .dm_rdata(dm_rdata12), .dm_ack(dm_ack12), .o_data(o_data12), .o_zero(o_zero12),
        .o_carry(o_carry12), .o_halted(o_halted12)
    );

    typedef struct packed {
        logic [7:0] acc;
        logic       z;
        logic       c;
        logic [4:0] pc;
    } exp_t;

    typedef struct packed {
        logic [31:0][15:0] img;
        exp_t              exp;
    } vec_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t vecs [NV];
    exp_t exp_q [$];
    wr_t  wq [$];

    int total = 0;
    int bad   = 0;

    // Data-memory model controls and observations.
    logic       dm_auto   = 1'b1;
    logic       force_ack = 1'b0;
    int         dm_lat    = 1;
    int         req_cnt   = 0;
    int         run_len   = 0;
    logic       run_we    = 1'b0;
    int         store_run = 0;
    int         unstable  = 0;
    int         idle_bad  = 0;
    logic [9:0] la;
    logic       lw;
    logic [7:0] ld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] opnd);
        return {op, opnd};
    endfunction

    task automatic set_ins(input int v, input int a, input logic [3:0] op,
                           input logic [11:0] opnd);
        vecs[v].img[a] = ins(op, opnd);
    endtask

    task automatic set_exp(input int v, input logic [7:0] acc, input logic z, input logic c,
                           input logic [4:0] pc);
        vecs[v].exp = '{acc: acc, z: z, c: c, pc: pc};
    endtask

    task automatic clear_pm();
        for (int a = 0; a < 32; a++) pm[a] = HaltIns;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic wait_halt(input int bound, output int cyc);
        cyc = 0;
        while (!o_halted && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Variable-latency data memory: ack in the dm_lat-th cycle of a request.
    always @(negedge clk) begin
        if (!dm_req && dm_we) idle_bad++;
        if (dm_req) begin
            if (run_len == 0) run_we = dm_we;
            run_len++;
        end else if (run_len != 0) begin
            if (run_we) store_run = run_len;
            run_len = 0;
        end
        dm_ack = 1'b0;
        if (force_ack) begin
            dm_ack = 1'b1;
        end else if (dm_auto && dm_req) begin
            if (req_cnt == 0) begin
                la = dm_addr;
                lw = dm_we;
                ld = dm_wdata;
            end else if (dm_addr !== la || dm_we !== lw || dm_wdata !== ld) begin
                unstable++;
            end
            req_cnt++;
            if (req_cnt == dm_lat) begin
                dm_ack   = 1'b1;
                dm_rdata = dmem[dm_addr];
                if (dm_we) begin
                    dmem[dm_addr] = dm_wdata;
                    if (wq.size() == 0) begin
                        check("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        wr_t w;
                        w = wq.pop_front();
                        check("wr_addr", 32'(dm_addr), 32'(w.addr));
                        check("wr_data", 32'(dm_wdata), 32'(w.data));
                    end
                end
                req_cnt = 0;
            end
        end else begin
            req_cnt = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        exp_t e;

        for (int a = 0; a < 1024; a++) dmem[a] = 8'h00;
        for (int a = 0; a < 32; a++) pm12[a] = HaltIns;
        pm12[0] = ins(4'h1, 12'hABC);

        for (int v = 0; v < NV; v++)
            for (int a = 0; a < 32; a++) vecs[v].img[a] = HaltIns;
        // 0: LDI 5; STR r1; LDI 3; ADD r1
        set_ins(0, 0, 4'h1, 12'h005); set_ins(0, 1, 4'h3, 12'h001);
        set_ins(0, 2, 4'h1, 12'h003); set_ins(0, 3, 4'h4, 12'h001);
        set_exp(0, 8'h08, 1'b0, 1'b0, 5'd4);
        // 1: LDI FF; STR r0; LDI 1; ADD r0 -> wrap to zero with carry
        set_ins(1, 0, 4'h1, 12'h0FF); set_ins(1, 1, 4'h3, 12'h000);
        set_ins(1, 2, 4'h1, 12'h001); set_ins(1, 3, 4'h4, 12'h000);
        set_exp(1, 8'h00, 1'b1, 1'b1, 5'd4);
        // 2: as 1, then SUB r0 (0 - FF) -> 01 with borrow
        set_ins(2, 0, 4'h1, 12'h0FF); set_ins(2, 1, 4'h3, 12'h000);
        set_ins(2, 2, 4'h1, 12'h001); set_ins(2, 3, 4'h4, 12'h000);
        set_ins(2, 4, 4'h5, 12'h000);
        set_exp(2, 8'h01, 1'b0, 1'b1, 5'd5);
        // 3: set carry, then MUL 0x12 * 0x10 -> 0x20, carry cleared
        set_ins(3, 0, 4'h1, 12'h0FF); set_ins(3, 1, 4'h3, 12'h000);
        set_ins(3, 2, 4'h4, 12'h000); set_ins(3, 3, 4'h1, 12'h010);
        set_ins(3, 4, 4'h3, 12'h002); set_ins(3, 5, 4'h1, 12'h012);
        set_ins(3, 6, 4'hD, 12'h002);
        set_exp(3, 8'h20, 1'b0, 1'b0, 5'd7);
        // 4: LDI 0; JZ 7 (taken); @7 LDI 1; JZ 2 (not taken); HALT @9
        set_ins(4, 0, 4'h1, 12'h000); set_ins(4, 1, 4'hC, 12'h007);
        set_ins(4, 7, 4'h1, 12'h001); set_ins(4, 8, 4'hC, 12'h002);
        set_exp(4, 8'h01, 1'b0, 1'b0, 5'd9);
        // 5: NOP at 31 wraps pc to 0; second pass ADDI makes acc 0 and JZ 5 taken
        set_ins(5, 0, 4'hC, 12'h005); set_ins(5, 1, 4'hB, 12'h01E);
        set_ins(5, 30, 4'hE, 12'h080); set_ins(5, 31, 4'h0, 12'h000);
        set_exp(5, 8'h00, 1'b1, 1'b1, 5'd5);
        // 6: same loop but JMP 0 placed at pc 31
        set_ins(6, 0, 4'hC, 12'h005); set_ins(6, 1, 4'hB, 12'h01D);
        set_ins(6, 29, 4'hE, 12'h080); set_ins(6, 30, 4'h0, 12'h000);
        set_ins(6, 31, 4'hB, 12'h000);
        set_exp(6, 8'h00, 1'b1, 1'b1, 5'd5);
        // 7: set carry, then AND/XOR/OR with 0x3C keep carry
        set_ins(7, 0, 4'h1, 12'h0FF); set_ins(7, 1, 4'h3, 12'h000);
        set_ins(7, 2, 4'h4, 12'h000); set_ins(7, 3, 4'h1, 12'h03C);
        set_ins(7, 4, 4'h3, 12'h003); set_ins(7, 5, 4'h1, 12'h0F0);
        set_ins(7, 6, 4'h6, 12'h003); set_ins(7, 7, 4'h8, 12'h003);
        set_ins(7, 8, 4'h7, 12'h003);
        set_exp(7, 8'h3C, 1'b0, 1'b1, 5'd9);
        // 8: LDI 77; STR r5; LDI 0; LDR r5
        set_ins(8, 0, 4'h1, 12'h077); set_ins(8, 1, 4'h3, 12'h005);
        set_ins(8, 2, 4'h1, 12'h000); set_ins(8, 3, 4'h2, 12'h005);
        set_exp(8, 8'h77, 1'b0, 1'b0, 5'd4);
        // 9: LDI 5A; STR r4; XOR r4 -> zero
        set_ins(9, 0, 4'h1, 12'h05A); set_ins(9, 1, 4'h3, 12'h004);
        set_ins(9, 2, 4'h8, 12'h004);
        set_exp(9, 8'h00, 1'b1, 1'b0, 5'd3);
        // 10: register operand 0x00D selects r5 (only bits [2:0] count)
        set_ins(10, 0, 4'h1, 12'h042); set_ins(10, 1, 4'h3, 12'h00D);
        set_ins(10, 2, 4'h1, 12'h000); set_ins(10, 3, 4'h2, 12'h005);
        set_exp(10, 8'h42, 1'b0, 1'b0, 5'd4);

        // Basic program: exactly 10 cycles to HALT, then pc frozen
        for (int a = 0; a < 32; a++) pm[a] = vecs[0].img[a];
        pulse_reset();
        wait_halt(50, cyc);
        check("cycles_to_halt", 32'(cyc), 32'd10);
        repeat (5) @(posedge clk);
        #1;
        check("halt_pc_frozen", 32'(pm_addr), 32'd4);
        check("halt_acc", 32'(o_data), 32'h08);
        check("halt_flag", 32'(o_halted), 32'd1);
        check("halt_no_req", 32'(dm_req), 32'd0);

        // Reset from a non-trivial state
        pulse_reset();
        check("rst_acc", 32'(o_data), 32'd0);
        check("rst_zero", 32'(o_zero), 32'd0);
        check("rst_carry", 32'(o_carry), 32'd0);
        check("rst_halted", 32'(o_halted), 32'd0);
        check("rst_pc", 32'(pm_addr), 32'd0);
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_we", 32'(dm_we), 32'd0);

        // Table-driven programs
        for (int v = 0; v < NV; v++) begin
            for (int a = 0; a < 32; a++) pm[a] = vecs[v].img[a];
            exp_q.push_back(vecs[v].exp);
            pulse_reset();
            wait_halt(400, cyc);
            check($sformatf("v%0d_halted", v), 32'(o_halted), 32'd1);
            e = exp_q.pop_front();
            check($sformatf("v%0d_acc", v), 32'(o_data), 32'(e.acc));
            check($sformatf("v%0d_zero", v), 32'(o_zero), 32'(e.z));
            check($sformatf("v%0d_carry", v), 32'(o_carry), 32'(e.c));
            check($sformatf("v%0d_pc", v), 32'(pm_addr), 32'(e.pc));
        end

        // STM 0x3A with 4-cycle ack latency, then LDM back
        clear_pm();
        pm[0] = ins(4'h1, 12'h05C);
        pm[1] = ins(4'hA, 12'h03A);
        pm[2] = ins(4'h1, 12'h000);
        pm[3] = ins(4'h9, 12'h03A);
        dm_lat = 4;
        wq.push_back('{addr: 10'h03A, data: 8'h5C});
        pulse_reset();
        wait_halt(100, cyc);
        check("mem_halted", 32'(o_halted), 32'd1);
        check("ldm_acc", 32'(o_data), 32'h5C);
        check("ldm_zero", 32'(o_zero), 32'd0);
        check("mem_pc", 32'(pm_addr), 32'd4);
        check("stm_req_cycles", 32'(store_run), 32'd4);
        check("mem_cycles", 32'(cyc), 32'd18);
        check("dmem_written", 32'(dmem[10'h03A]), 32'h5C);
        check("wr_queue_empty", 32'(wq.size()), 32'd0);

        // clr while waiting in MEM; the following ack must be ignored
        clear_pm();
        pm[0] = ins(4'h1, 12'h011);
        pm[1] = ins(4'hA, 12'h010);
        dm_auto = 1'b0;
        pulse_reset();
        cyc = 0;
        while (!dm_req && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_req_seen", 32'(dm_req), 32'd1);
        check("abort_acc_before", 32'(o_data), 32'h11);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        force_ack = 1'b1;
        check("abort_req_dropped", 32'(dm_req), 32'd0);
        check("abort_acc_reset", 32'(o_data), 32'd0);
        check("abort_pc_reset", 32'(pm_addr), 32'd0);
        @(posedge clk);
        #1 force_ack = 1'b0;
        check("abort_ack_ignored_pc", 32'(pm_addr), 32'd0);
        check("abort_ack_ignored_acc", 32'(o_data), 32'd0);
        check("abort_ack_ignored_req", 32'(dm_req), 32'd0);
        wq.push_back('{addr: 10'h010, data: 8'h11});
        dm_lat  = 2;
        dm_auto = 1'b1;
        wait_halt(100, cyc);
        check("restart_halted", 32'(o_halted), 32'd1);
        check("restart_acc", 32'(o_data), 32'h11);
        check("restart_pc", 32'(pm_addr), 32'd2);
        check("restart_wq_empty", 32'(wq.size()), 32'd0);

        // 12-bit build ran the same resets alongside
        check("w12_acc", 32'(o_data12), 32'hABC);
        check("w12_halted", 32'(o_halted12), 32'd1);
        check("w12_zero", 32'(o_zero12), 32'd0);

        check("dm_stable", 32'(unstable), 32'd0);
        check("dm_we_idle", 32'(idle_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_cpu_mc.md
Name: acc_cpu_mc

Overview:
- Parametrised multi-cycle accumulator CPU core; next generation of the 8-bit single-cycle accumulator CPU.
- Generalised in data width, program-counter width and data-memory address width.
- Adds a fetch/execute state machine, a req/ack handshake to data memory, flags, conditional jumps and a HALT state.
- Program memory is external and combinational; data memory is external with variable latency.

Parameters:
DATA_W, 8, accumulator/register/data-memory word width (4..12)
PC_W, 5, program counter width; program space is 2**PC_W words
MEM_AW, 10, data-memory address width (<=12)
NREG, 8, register-file depth; register index is instr[2:0], bits above NREG-1 ignored modulo NREG

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  synchronous active-high reset
pm_addr  out  PC_W  program memory address (= pc)
pm_data  in  16  instruction word, valid combinationally for pm_addr
dm_req  out  1  data-memory request, held until dm_ack
dm_we  out  1  1 = write, 0 = read; valid while dm_req
dm_addr  out  MEM_AW  data-memory address; valid while dm_req
dm_wdata  out  DATA_W  write data (= acc); valid while dm_req
dm_rdata  in  DATA_W  read data, sampled in the cycle dm_ack=1
dm_ack  in  1  one-cycle completion strobe
o_data  out  DATA_W  accumulator value
o_zero  out  1  zero flag
o_carry  out  1  carry/borrow flag
o_halted  out  1  1 while in HALT

Behaviour:
- Instruction format: op=instr[15:12], operand=instr[11:0]; imm = operand[DATA_W-1:0]; addr = operand[MEM_AW-1:0]; r = operand[2:0] mod NREG; jump target = operand[PC_W-1:0].
- Opcodes: 0 NOP; 1 LDI acc=imm; 2 LDR acc=R[r]; 3 STR R[r]=acc; 4 ADD acc+=R[r]; 5 SUB acc-=R[r]; 6 AND; 7 OR; 8 XOR (all with R[r]); 9 LDM acc=mem[addr]; A STM mem[addr]=acc; B JMP; C JZ (jump if o_zero); D MUL acc=low DATA_W bits of acc*R[r]; E ADDI acc+=imm; F HALT.
- Arithmetic is modulo 2**DATA_W. ADD/ADDI: carry = bit DATA_W of the sum. SUB: carry = borrow (acc < R[r]).
- o_zero is updated on every acc write (LDI/LDR/ALU/LDM/MUL/ADDI) to (new acc == 0). o_carry is updated only by ADD/SUB/ADDI and cleared by MUL. Other instructions hold both flags.
- FSM states: FETCH, EXEC, MEM, HALT.
  - FETCH: ir <= pm_data; go to EXEC. 1 cycle.
  - EXEC: non-memory ops commit and pc <= pc+1 (wrapping at 2**PC_W), or pc <= target for a taken JMP/JZ; go to FETCH. LDM/STM go to MEM. HALT goes to HALT with pc unchanged.
  - MEM: dm_req=1 with dm_we/dm_addr/dm_wdata stable. On dm_ack: LDM writes acc; pc <= pc+1; go to FETCH. Stays in MEM indefinitely without ack.
  - HALT: terminal until clr; dm_req=0; no state changes.
- Latency: 2 cycles per non-memory instruction; 3+N for memory, where N = cycles before ack. dm_ack outside MEM is ignored.
- Reset (clr=1 at an edge): pc=0, acc=0, all R=0, ir=0, flags=0, state=FETCH, dm_req=0, dm_we=0, o_halted=0. clr overrides everything, including mid-MEM: the request is dropped on the next cycle and a pending ack is ignored.
- dm_req/dm_we/dm_addr/dm_wdata are registered, or decoded from state+ir only. They must be glitch-free relative to clk and 0/stable outside MEM.

Test Plan:
- Reset then LDI 5; STR r1; LDI 3; ADD r1; HALT -> o_data=8, o_zero=0, o_carry=0, o_halted=1 after 10 cycles; pc frozen at 4.
- DATA_W=8: LDI 0xFF; STR r0; LDI 1; ADD r0 -> o_data=0x00, o_zero=1, o_carry=1; then SUB r0 (0-0xFF) -> o_data=0x01, o_carry=1.
- STM addr 0x3A with acc=0x5C, ack after 4 cycles -> dm_req high exactly 4 cycles, dm_we=1, dm_addr=0x3A, dm_wdata=0x5C; LDM 0x3A with dm_rdata=0x5C -> o_data=0x5C.
- LDI 0; JZ 7 -> pc=7; LDI 1; JZ 2 -> pc increments (not taken); JMP at pc=31 with PC_W=5 to 0 -> wraps correctly; NOP at 31 -> pc=0.
- MUL: acc=0x12, R2=0x10 -> o_data=0x20, o_carry=0; DATA_W=12 build: LDI 0xABC -> o_data=0xABC.
- Assert clr while in MEM awaiting ack, pulse dm_ack the next cycle -> dm_req=0 and all state reset; the ack has no effect; execution restarts at pc=0.
